// File: rtl/eth_backoff_gen.sv
// eth_backoff_gen: truncated binary exponential backoff engine for the MAC transmit path
// Free-running XNOR LFSR, retry-masked random slot count, slot timer and busy/done handshake.
module eth_backoff_gen #(
    parameter int LFSR_W        = 10,
    parameter int LFSR_TAP      = 2,
    parameter int BACKOFF_LIMIT = 10,
    parameter int SLOT_NIBBLES  = 128,
    parameter int SLOT_W        = 7
) (
    input  logic              MTxClk,
    input  logic              Resetn,
    input  logic              StartBackoff,
    input  logic [3:0]        RetryCnt,
    input  logic              Abort,
    input  logic              SeedLoad,
    input  logic [LFSR_W-1:0] Seed,
    output logic              BackoffBusy,
    output logic              BackoffDone,
    output logic              RandomEq0,
    output logic [LFSR_W-1:0] RandomLatched,
    output logic [LFSR_W-1:0] SlotsLeft
);
    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

    state_t            state, stateNext;
    logic [LFSR_W-1:0] lfsr, mask, random;
    logic [SLOT_W-1:0] slotCnt;
    logic              feedback, start, slotWrap;

    assign feedback    = ~(lfsr[LFSR_TAP] ^ lfsr[LFSR_W-1]);
    assign random      = lfsr & mask;
    assign BackoffBusy = (state != IDLE);
    assign BackoffDone = (state == DONE);
    assign RandomEq0   = (RandomLatched == '0);

    // bit i survives when i < min(RetryCnt, BACKOFF_LIMIT); bit 0 always survives
    always_comb begin
        mask = '0;
        for (int i = 0; i < LFSR_W; i++)
            mask[i] = (i == 0) || ((i < BACKOFF_LIMIT) && (i < {28'd0, RetryCnt}));
    end

    always_comb begin
        stateNext = state;
        start     = (state == IDLE) && StartBackoff && !Abort;
        slotWrap  = (state == COUNT) && (slotCnt == SLOT_W'(SLOT_NIBBLES - 1));
        if (Abort)
            stateNext = IDLE;
        else
            case (state)
                IDLE:    if (StartBackoff) stateNext = (random == '0) ? DONE : COUNT;
                COUNT:   if (slotWrap && SlotsLeft == LFSR_W'(1)) stateNext = DONE;
                default: stateNext = IDLE;
            endcase
    end

    always_ff @(posedge MTxClk or negedge Resetn)
        if (!Resetn)
            state <= IDLE;
        else
            state <= stateNext;

    always_ff @(posedge MTxClk or negedge Resetn)
        if (!Resetn) begin
            lfsr          <= '0;
            RandomLatched <= '0;
            SlotsLeft     <= '0;
            slotCnt       <= '0;
        end else begin
            // the all-ones seed would lock the XNOR register, so it maps to zero
            lfsr <= SeedLoad ? ((&Seed) ? '0 : Seed) : {lfsr[LFSR_W-2:0], feedback};
            if (start) begin
                RandomLatched <= random;
                SlotsLeft     <= random;
                slotCnt       <= '0;
            end else if (Abort) begin
                SlotsLeft <= '0;
                slotCnt   <= '0;
            end else if (state == COUNT) begin
                slotCnt <= slotWrap ? '0 : slotCnt + SLOT_W'(1);
                if (slotWrap) SlotsLeft <= SlotsLeft - LFSR_W'(1);
            end
        end
endmodule

// File: tb/tb_eth_backoff_gen.sv
// tb_eth_backoff_gen: directed self-checking bench for eth_backoff_gen
// A second instance with 4-cycle slots exercises the exponent cap in reasonable time.
module tb_eth_backoff_gen;
    logic       MTxClk = 1'b0;
    logic       Resetn, StartBackoff, StartBackoff4, Abort, SeedLoad;
    logic [3:0] RetryCnt;
    logic [9:0] Seed;
    logic       busy, done, eq0, busy4, done4, eq04;
    logic [9:0] rl, sl, rl4, sl4;
    int         errors = 0;
    int         checks = 0;

    always #5 MTxClk = ~MTxClk;

    eth_backoff_gen dut (
        .MTxClk(MTxClk), .Resetn(Resetn), .StartBackoff(StartBackoff), .RetryCnt(RetryCnt),
        .Abort(Abort), .SeedLoad(SeedLoad), .Seed(Seed), .BackoffBusy(busy),
        .BackoffDone(done), .RandomEq0(eq0), .RandomLatched(rl), .SlotsLeft(sl)
    );

    eth_backoff_gen #(.SLOT_NIBBLES(4), .SLOT_W(2)) dut4 (
        .MTxClk(MTxClk), .Resetn(Resetn), .StartBackoff(StartBackoff4), .RetryCnt(RetryCnt),
        .Abort(Abort), .SeedLoad(SeedLoad), .Seed(Seed), .BackoffBusy(busy4),
        .BackoffDone(done4), .RandomEq0(eq04), .RandomLatched(rl4), .SlotsLeft(sl4)
    );

    task automatic tick();
        @(posedge MTxClk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic seed(input logic [9:0] s);
        SeedLoad = 1'b1;
        Seed     = s;
        tick();
        SeedLoad = 1'b0;
    endtask

    initial begin
        Resetn = 1'b0; StartBackoff = 1'b0; StartBackoff4 = 1'b0; Abort = 1'b0;
        SeedLoad = 1'b0; RetryCnt = 4'd0; Seed = 10'd0;
        ticks(2);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_eq0", eq0, 1);
        chk("rst_rl", rl, 0);
        chk("rst_sl", sl, 0);
        Resetn = 1'b1;
        chk("lfsr0", dut.lfsr, 10'h000);
        tick();
        chk("lfsr1", dut.lfsr, 10'h001);
        tick();
        chk("lfsr3", dut.lfsr, 10'h003);

        // R=1: one slot of 128 edges
        seed(10'h001);
        chk("seed1", dut.lfsr, 10'h001);
        StartBackoff = 1'b1; RetryCnt = 4'd1;
        tick();
        StartBackoff = 1'b0;
        chk("t2_rl", rl, 1);
        chk("t2_sl", sl, 1);
        chk("t2_busy", busy, 1);
        chk("t2_eq0", eq0, 0);
        ticks(127);
        chk("t2_early_done", done, 0);
        chk("t2_early_sl", sl, 1);
        tick();
        chk("t2_done", done, 1);
        chk("t2_done_sl", sl, 0);
        chk("t2_done_busy", busy, 1);
        tick();
        chk("t2_after_done", done, 0);
        chk("t2_after_busy", busy, 0);

        // R=0: straight to DONE
        seed(10'h002);
        StartBackoff = 1'b1; RetryCnt = 4'd1;
        tick();
        chk("t3_done", done, 1);
        chk("t3_eq0", eq0, 1);
        chk("t3_rl", rl, 0);
        // start during DONE is ignored (x is now 0x005, so a relatch would give 5)
        RetryCnt = 4'd15;
        tick();
        StartBackoff = 1'b0;
        chk("t6_done_ign_rl", rl, 0);
        chk("t6_done_ign_busy", busy, 0);
        chk("t3_after_done", done, 0);

        // R=3, abort after two slots
        seed(10'h003);
        StartBackoff = 1'b1; RetryCnt = 4'd2;
        tick();
        StartBackoff = 1'b0;
        chk("t5_rl", rl, 3);
        chk("t5_sl", sl, 3);
        ticks(256);
        chk("t5_sl_mid", sl, 1);
        chk("t5_busy_mid", busy, 1);
        Abort = 1'b1;
        tick();
        Abort = 1'b0;
        chk("t5_abort_busy", busy, 0);
        chk("t5_abort_sl", sl, 0);
        chk("t5_abort_done", done, 0);
        chk("t5_abort_rl", rl, 3);
        tick();
        chk("t5_no_done", done, 0);

        // lockup seed maps to zero
        seed(10'h3FF);
        chk("t6_lockup", dut.lfsr, 10'h000);

        // start while busy is ignored
        seed(10'h001);
        StartBackoff = 1'b1; RetryCnt = 4'd1;
        tick();
        chk("t6_busy_rl", rl, 1);
        RetryCnt = 4'd15;
        ticks(3);
        StartBackoff = 1'b0;
        chk("t6_ign_rl", rl, 1);
        chk("t6_ign_sl", sl, 1);
        Abort = 1'b1;
        tick();
        // abort has priority over a same-edge start
        StartBackoff = 1'b1;
        tick();
        Abort = 1'b0; StartBackoff = 1'b0;
        chk("t6_prio_busy", busy, 0);
        chk("t6_prio_rl", rl, 1);
        chk("t6_prio_sl", sl, 0);

        // exponent capped at 10 on the 4-cycle-slot instance
        seed(10'h3FE);
        StartBackoff4 = 1'b1; RetryCnt = 4'd15;
        tick();
        StartBackoff4 = 1'b0;
        chk("t4_rl", rl4, 10'h3FE);
        chk("t4_sl", sl4, 10'h3FE);
        chk("t4_busy", busy4, 1);
        ticks(4087);
        chk("t4_early_done", done4, 0);
        chk("t4_early_sl", sl4, 1);
        tick();
        chk("t4_done", done4, 1);
        tick();
        chk("t4_after_done", done4, 0);
        chk("t4_after_busy", busy4, 0);

        // asynchronous reset mid-COUNT
        seed(10'h001);
        StartBackoff = 1'b1; RetryCnt = 4'd1;
        tick();
        StartBackoff = 1'b0;
        ticks(10);
        chk("t1_pre_busy", busy, 1);
        #2;
        Resetn = 1'b0;
        #1;
        chk("t1_busy", busy, 0);
        chk("t1_done", done, 0);
        chk("t1_eq0", eq0, 1);
        chk("t1_rl", rl, 0);
        chk("t1_sl", sl, 0);
        tick();
        Resetn = 1'b1;
        tick();
        chk("t1_lfsr1", dut.lfsr, 10'h001);
        tick();
        chk("t1_lfsr3", dut.lfsr, 10'h003);
        tick();
        chk("t1_lfsr7", dut.lfsr, 10'h007);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
